// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue path: opcode encoding, default latencies, one-hot select.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package fpu_pkg;

    typedef enum logic [2:0] {
        FADD = 3'd0,
        FSUB = 3'd1,
        FMUL = 3'd2,
        FDIV = 3'd3,
        FEQ  = 3'd4,
        FLT  = 3'd5,
        FLE  = 3'd6
    } fpu_op_e;

    localparam int FPU_SEL_W       = 7;
    localparam int FPU_LAT_ADD_DEF = 2;
    localparam int FPU_LAT_MUL_DEF = 3;
    localparam int FPU_LAT_DIV_DEF = 8;
    localparam int FPU_LAT_CMP_DEF = 1;

    // One-hot select, bit 0 = fadd; undefined codes select no FPU path
    function automatic logic [FPU_SEL_W-1:0] fpu_op_onehot(input fpu_op_e op);
        case (op)
            FADD:    return 7'b000_0001;
            FSUB:    return 7'b000_0010;
            FMUL:    return 7'b000_0100;
            FDIV:    return 7'b000_1000;
            FEQ:     return 7'b001_0000;
            FLT:     return 7'b010_0000;
            FLE:     return 7'b100_0000;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_seq.sv
// Multi-cycle issue sequencer feeding a combinational FPU; registers operands/one-hot op, waits per-op latency, captures result.
// Latency: result captured L edges after acceptance (L per op, 0 treated as 1); one op in flight, L+2 cycles per op best case.
// Backpressure: req_ready only in IDLE; out_ready low in DONE holds out_* indefinitely. Option macro: FPU_SEQ_STICKY_OVF_EN.
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int LAT_ADD = FPU_LAT_ADD_DEF,
    parameter int LAT_MUL = FPU_LAT_MUL_DEF,
    parameter int LAT_DIV = FPU_LAT_DIV_DEF,
    parameter int LAT_CMP = FPU_LAT_CMP_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [31:0]          req_src1,
    input  logic [31:0]          req_src2,
    input  logic [4:0]           req_rd,
    output logic [31:0]          fpu_src1,
    output logic [31:0]          fpu_src2,
    output logic [FPU_SEL_W-1:0] fpu_sel,
    input  logic [31:0]          fpu_result,
    input  logic                 fpu_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_ovf,
    output logic [4:0]           out_rd,
    output logic                 busy,
    output logic                 sticky_ovf,
    input  logic                 sticky_clr
);

    // Zero latency would leave no cycle for the FPU to settle, so clamp to 1
    localparam int LAT_ADD_E = (LAT_ADD < 1) ? 1 : LAT_ADD;
    localparam int LAT_MUL_E = (LAT_MUL < 1) ? 1 : LAT_MUL;
    localparam int LAT_DIV_E = (LAT_DIV < 1) ? 1 : LAT_DIV;
    localparam int LAT_CMP_E = (LAT_CMP < 1) ? 1 : LAT_CMP;
    localparam int MAX_AM    = (LAT_ADD_E > LAT_MUL_E) ? LAT_ADD_E : LAT_MUL_E;
    localparam int MAX_DC    = (LAT_DIV_E > LAT_CMP_E) ? LAT_DIV_E : LAT_CMP_E;
    localparam int MAX_LAT   = (MAX_AM > MAX_DC) ? MAX_AM : MAX_DC;
    localparam int CNT_W     = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_m1;
    logic             acc;
    logic             cap;
    logic             wb;

    assign req_ready = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc       = req_valid && req_ready;
    assign cap       = (state_q == EXEC) && (cnt_q == '0);
    assign wb        = (state_q == DONE) && out_ready;

    // Counter preload (latency - 1) for the op being accepted; undefined codes take one cycle
    always_comb begin
        lat_m1 = '0;
        case (fpu_op_e'(req_op))
            FADD, FSUB:     lat_m1 = CNT_W'(LAT_ADD_E - 1);
            FMUL:           lat_m1 = CNT_W'(LAT_MUL_E - 1);
            FDIV:           lat_m1 = CNT_W'(LAT_DIV_E - 1);
            FEQ, FLT, FLE:  lat_m1 = CNT_W'(LAT_CMP_E - 1);
            default:        lat_m1 = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: accept -> count down -> hold result until writeback takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = EXEC;
            EXEC:    if (cap) state_d = DONE;
            DONE:    if (wb)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand/select issue registers, latency counter and result capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q      <= '0;
            fpu_src1   <= '0;
            fpu_src2   <= '0;
            fpu_sel    <= '0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_rd     <= '0;
        end else begin
            if (acc) begin
                cnt_q    <= lat_m1;
                fpu_src1 <= req_src1;
                fpu_src2 <= req_src2;
                fpu_sel  <= fpu_op_onehot(fpu_op_e'(req_op));
                out_rd   <= req_rd;
            end
            if ((state_q == EXEC) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
            if (cap) begin
                out_result <= fpu_result;
                out_ovf    <= fpu_ovf;
            end
            // Drop the select once the result is handed off so the FPU idles
            if (wb) fpu_sel <= '0;
        end
    end

`ifdef FPU_SEQ_STICKY_OVF_EN
    // Sticky overflow: set on a writeback carrying ovf, set beats a same-cycle clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)               sticky_ovf <= 1'b0;
        else if (wb && out_ovf)  sticky_ovf <= 1'b1;
        else if (sticky_clr)     sticky_ovf <= 1'b0;
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_seq.sv
// Directed bench for fpu_seq with a tiny behavioural FPU answering the fixed operand vectors.
// Latency: checks exact acceptance-to-out_valid cycle counts per op class.
// Backpressure: exercises out_ready stall in DONE and a held second request.
module tb_fpu_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic [4:0]  req_rd;
    logic [31:0] fpu_src1;
    logic [31:0] fpu_src2;
    logic [6:0]  fpu_sel;
    logic [31:0] fpu_result;
    logic        fpu_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic [4:0]  out_rd;
    logic        busy;
    logic        sticky_ovf;
    logic        sticky_clr;

    int errs  = 0;
    int n_chk = 0;

`ifdef FPU_SEQ_STICKY_OVF_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    fpu_seq #(
        .LAT_ADD(2),
        .LAT_MUL(3),
        .LAT_DIV(8),
        .LAT_CMP(1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .req_rd     (req_rd),
        .fpu_src1   (fpu_src1),
        .fpu_src2   (fpu_src2),
        .fpu_sel    (fpu_sel),
        .fpu_result (fpu_result),
        .fpu_ovf    (fpu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_rd     (out_rd),
        .busy       (busy),
        .sticky_ovf (sticky_ovf),
        .sticky_clr (sticky_clr)
    );

    // Behavioural FPU: hand-computed answers for the vectors used below
    always_comb begin
        fpu_result = 32'h0;
        fpu_ovf    = 1'b0;
        case (fpu_sel)
            7'b000_0001: fpu_result = (fpu_src1 == 32'h3F80_0000 && fpu_src2 == 32'h4000_0000)
                                      ? 32'h4040_0000 : 32'hDEAD_BEEF;
            7'b000_0100: begin
                if (fpu_src1 == 32'h7F00_0000 && fpu_src2 == 32'h7F00_0000) begin
                    fpu_result = 32'h7F80_0000;
                    fpu_ovf    = 1'b1;
                end else begin
                    fpu_result = 32'hDEAD_BEEF;
                end
            end
            7'b000_1000: fpu_result = (fpu_src1 == 32'h4040_0000 && fpu_src2 == 32'h4000_0000)
                                      ? 32'h3FC0_0000 : 32'hDEAD_BEEF;
            7'b100_0000: fpu_result = (fpu_src1 <= fpu_src2) ? 32'h1 : 32'h0;
            default:     fpu_result = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after acceptance
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_rd    = rd;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count rising edges (including the one already passed since acceptance) until out_valid
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid) n++;
        end
        if (!out_valid) n = 99;
    endtask

    initial begin
        int n;
        logic [31:0] held;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_src1   = '0;
        req_src2   = '0;
        req_rd     = '0;
        out_ready  = 1'b1;
        sticky_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fpu_sel", 32'(fpu_sel), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        rstn = 1'b1;

        // fadd 1.0 + 2.0, latency 2
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        chk("add_sel", 32'(fpu_sel), 32'h01);
        chk("add_src1", fpu_src1, 32'h3F80_0000);
        chk("add_src2", fpu_src2, 32'h4000_0000);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_req_ready", 32'(req_ready), 32'd0);
        wait_out(n);
        chk("add_lat", 32'(n), 32'd2);
        chk("add_res", out_result, 32'h4040_0000);
        chk("add_ovf", 32'(out_ovf), 32'd0);
        chk("add_rd", 32'(out_rd), 32'd5);
        @(negedge clk);
        chk("add_wb_valid", 32'(out_valid), 32'd0);
        chk("add_wb_ready", 32'(req_ready), 32'd1);
        chk("add_wb_sel", 32'(fpu_sel), 32'd0);

        // fle 1.0 <= 2.0, latency 1
        issue(3'd6, 32'h3F80_0000, 32'h4000_0000, 5'd9);
        chk("fle_sel", 32'(fpu_sel), 32'h40);
        wait_out(n);
        chk("fle_lat", 32'(n), 32'd1);
        chk("fle_res", out_result, 32'h1);
        chk("fle_rd", 32'(out_rd), 32'd9);
        @(negedge clk);

        // fmul overflow, latency 3, sticky behaviour
        issue(3'd2, 32'h7F00_0000, 32'h7F00_0000, 5'd12);
        chk("mul_sel", 32'(fpu_sel), 32'h04);
        wait_out(n);
        chk("mul_lat", 32'(n), 32'd3);
        chk("mul_res", out_result, 32'h7F80_0000);
        chk("mul_ovf", 32'(out_ovf), 32'd1);
        chk("mul_sticky_pre", 32'(sticky_ovf), 32'd0);
        @(negedge clk);
        chk("mul_sticky", 32'(sticky_ovf), 32'(STICKY_EXP));
        @(negedge clk);
        chk("mul_sticky_hold", 32'(sticky_ovf), 32'(STICKY_EXP));
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_clr", 32'(sticky_ovf), 32'd0);

        // fdiv 3.0 / 2.0 with writeback stalled, second request held meanwhile
        out_ready = 1'b0;
        issue(3'd3, 32'h4040_0000, 32'h4000_0000, 5'd17);
        chk("div_sel", 32'(fpu_sel), 32'h08);
        wait_out(n);
        chk("div_lat", 32'(n), 32'd8);
        chk("div_res", out_result, 32'h3FC0_0000);
        chk("div_rd", 32'(out_rd), 32'd17);
        held      = out_result;
        req_op    = 3'd0;
        req_src1  = 32'h3F80_0000;
        req_src2  = 32'h4000_0000;
        req_rd    = 5'd3;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_res", out_result, held);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        chk("stall_rd", 32'(out_rd), 32'd17);
        out_ready = 1'b1;
        @(negedge clk);
        chk("div_wb_ready", 32'(req_ready), 32'd1);
        chk("div_wb_valid", 32'(out_valid), 32'd0);
        chk("div_wb_sel", 32'(fpu_sel), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req2_busy", 32'(busy), 32'd1);
        chk("req2_sel", 32'(fpu_sel), 32'h01);
        wait_out(n);
        chk("req2_lat", 32'(n), 32'd2);
        chk("req2_res", out_result, 32'h4040_0000);
        chk("req2_rd", 32'(out_rd), 32'd3);
        @(negedge clk);

        // Asynchronous reset in the middle of an fdiv
        issue(3'd3, 32'h4040_0000, 32'h4000_0000, 5'd21);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_sel", 32'(fpu_sel), 32'd0);
        chk("arst_src1", fpu_src1, 32'd0);
        chk("arst_res", out_result, 32'd0);
        chk("arst_rd", 32'(out_rd), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        chk("arst_req_ready", 32'(req_ready), 32'd1);
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd7);
        wait_out(n);
        chk("post_rst_lat", 32'(n), 32'd2);
        chk("post_rst_res", out_result, 32'h4040_0000);
        chk("post_rst_rd", 32'(out_rd), 32'd7);
        @(negedge clk);

        // Undefined opcode: latency 1, no FPU path selected, zero result
        issue(3'd7, 32'h3F80_0000, 32'h4000_0000, 5'd30);
        chk("op7_sel", 32'(fpu_sel), 32'd0);
        chk("op7_busy", 32'(busy), 32'd1);
        wait_out(n);
        chk("op7_lat", 32'(n), 32'd1);
        chk("op7_res", out_result, 32'd0);
        chk("op7_ovf", 32'(out_ovf), 32'd0);
        chk("op7_rd", 32'(out_rd), 32'd30);
        chk("op7_sel_done", 32'(fpu_sel), 32'd0);
        @(negedge clk);
        chk("op7_wb_ready", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_seq.md
# fpu_seq

Multi-cycle issue sequencer that sits directly upstream of the combinational FPU datapath. It accepts one floating-point operation at a time over a valid/ready handshake and registers the operands and a one-hot opcode that drive the FPU. It then waits a per-operation latency so the FPU paths can be constrained as multicycle, and captures `result`/`ovf` into an output register held for writeback.

## Interface
Parameters:
- `LAT_ADD`, default 2: cycles for fadd/fsub.
- `LAT_MUL`, default 3: cycles for fmul.
- `LAT_DIV`, default 8: cycles for fdiv.
- `LAT_CMP`, default 1: cycles for feq/flt/fle.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 3: `fpu_op_e` code.
- `req_src1` in 32: operand 1.
- `req_src2` in 32: operand 2.
- `req_rd` in 5: destination register tag.
- `fpu_src1` out 32: registered operand 1 to the FPU.
- `fpu_src2` out 32: registered operand 2 to the FPU.
- `fpu_sel` out 7: one-hot {fle,flt,feq,fdiv,fmul,fsub,fadd}, bit 0 = fadd.
- `fpu_result` in 32: FPU result.
- `fpu_ovf` in 1: FPU overflow.
- `out_valid` out 1: captured result available.
- `out_ready` in 1: writeback accepts the result.
- `out_result` out 32: captured result.
- `out_ovf` out 1: captured overflow.
- `out_rd` out 5: tag of the completed operation.
- `busy` out 1: high whenever the state is not IDLE; used as a pipeline stall.
- `sticky_ovf` out 1: accumulated overflow (see Configuration).
- `sticky_clr` in 1: clears `sticky_ovf`.

## Operation
- The FSM has three states: IDLE, EXEC and DONE.
- `req_ready` = (state == IDLE).
- **IDLE:**
  - On `req_valid && req_ready`, register src1, src2, rd and `fpu_sel`, and load `cnt` with latency−1. Go to EXEC.
- **EXEC:**
  - `fpu_src*` and `fpu_sel` stay stable for the whole state.
  - `cnt` decrements by 1 each cycle.
  - When `cnt == 0`, capture `fpu_result` and `fpu_ovf` into `out_*` and go to DONE.
- **DONE:**
  - `out_valid` = 1.
  - On `out_ready`, go to IDLE and clear `fpu_sel` to 0.
  - `out_*` hold their values until the next capture.
- Latency per op:
  - fadd and fsub use `LAT_ADD`.
  - fmul uses `LAT_MUL`.
  - fdiv uses `LAT_DIV`.
  - feq, flt and fle use `LAT_CMP`.
  - A parameter value of 0 is treated as 1.
  - `cnt` width is $clog2(max latency)+1.
- Undefined `req_op` codes (7) are accepted with latency 1. `fpu_sel` = 0, so the captured result is 0 and ovf is 0.
- A request arriving while the sequencer is not IDLE is not accepted. The requester must hold `req_*` stable until `req_ready`.
- Reset (asynchronous, any state) does the following:
  - state goes to IDLE and `cnt` to 0.
  - `fpu_src*` and `fpu_sel` go to 0.
  - `out_valid`, `out_result`, `out_ovf`, `out_rd` and `sticky_ovf` go to 0.
  - Any in-flight operation is discarded.

## Timing
- A request accepted at edge T drives `fpu_*` from T.
- The result is captured at edge T+L, and `out_valid` rises after T+L.
- With `out_ready` held high, `out_valid` is high for 1 cycle and `req_ready` rises after edge T+L+1.
- Best-case throughput is one operation per L+2 cycles.
- `out_ready` low in DONE holds `out_valid` and all `out_*` indefinitely.
- `busy` is registered-state-derived, with no combinational path from `req_valid`.

## Configuration
- `FPU_SEQ_STICKY_OVF_EN` defined:
  - `sticky_ovf` is set at the DONE→IDLE handshake cycle when `out_ovf` = 1.
  - It is cleared by `sticky_clr`. If both happen in the same cycle, set wins.
- `FPU_SEQ_STICKY_OVF_EN` undefined:
  - `sticky_ovf` is tied 0 and `sticky_clr` is ignored.
- The ports exist in both builds.

## Structure
- Package `fpu_pkg` holds the following:
  - `fpu_op_e`: FADD=0, FSUB=1, FMUL=2, FDIV=3, FEQ=4, FLT=5, FLE=6.
  - The default latency localparams.
  - Function `fpu_op_onehot(fpu_op_e)`, returning the 7-bit `fpu_sel`.
- No sub-module: the FSM, counter and capture registers live in `fpu_seq`.

## Test plan
- fadd 0x3F800000 + 0x40000000 with `LAT_ADD`=2 and `out_ready`=1 -> `out_valid` exactly 2 cycles after acceptance, `out_result`=0x40400000, `out_ovf`=0, and `out_rd` equals the request tag.
- fle 0x3F800000, 0x40000000 with `LAT_CMP`=1 -> `out_result`=0x00000001 one cycle after acceptance.
- fmul 0x7F000000 × 0x7F000000 with the macro defined -> `out_ovf`=1 and `sticky_ovf`=1 after handshake. A `sticky_clr` pulse -> 0. With the macro undefined, `sticky_ovf` stays 0.
- fdiv with `out_ready`=0 for 5 cycles after `out_valid` -> outputs stable, `req_ready`=0, and a second `req_valid` is not accepted until the cycle after `out_ready`=1.
- `rstn` low at cycle 3 of an 8-cycle fdiv -> all outputs 0 immediately. After release, `req_ready`=1 and a new fadd completes normally.
- `req_op`=7 -> `out_result`=0 and `out_ovf`=0 after 1 cycle, with `fpu_sel`=0 throughout.
